// File: rtl/move_entry.sv
// Player move entry: synchronizes/debounces the select key, validates the one-hot switch move
// against board occupancy and offers an encoded index over valid/ready. Option: MOVE_TIMEOUT_EN.
module move_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
  input  logic       MAX10_CLK1_50,
  input  logic       rst,
  input  logic       key_n,
  input  logic [8:0] sw,
  input  logic [8:0] board_occ,
  output logic       move_valid,
  output logic [3:0] move_idx,
  input  logic       move_ready,
  output logic       err_multi,
  output logic       err_occupied,
  output logic       err_timeout
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DbW-1:0]  DbMax  = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES - 1);
`ifdef MOVE_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StCheck, StOffer, StWaitRelease} state_e;

  state_e          state_q, state_d;
  logic            key_s1_q, key_s2_q, key_deb_q, key_deb_d, key_deb_prev_q;
  logic [8:0]      sw_s1_q, sw_s2_q, sw_q, sw_d;
  logic [DbW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            move_valid_q, move_valid_d;
  logic [3:0]      move_idx_q, move_idx_d;
  logic            err_multi_q, err_multi_d, err_occ_q, err_occ_d, err_tmo_q, err_tmo_d;
  logic            press;
  logic [3:0]      ones, hot_idx;

  always_comb begin
    key_deb_d = key_deb_q;
    deb_cnt_d = deb_cnt_q;
    if (key_s2_q == key_deb_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DbMax) begin
      key_deb_d = key_s2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Registered falling edge of the debounced level puts CHECK one cycle after the fall.
  assign press = key_deb_prev_q & ~key_deb_q;

  always_comb begin
    ones    = '0;
    hot_idx = '0;
    for (int i = 0; i < 9; i++) begin
      if (sw_q[i]) begin
        ones    = ones + 1'b1;
        hot_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sw_d         = sw_q;
    tmo_cnt_d    = tmo_cnt_q;
    move_valid_d = move_valid_q;
    move_idx_d   = move_idx_q;
    err_multi_d  = 1'b0;
    err_occ_d    = 1'b0;
    err_tmo_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          sw_d    = sw_s2_q;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (ones != 4'd1) begin
          err_multi_d = 1'b1;
          state_d     = StWaitRelease;
        end else if (board_occ[hot_idx]) begin
          err_occ_d = 1'b1;
          state_d   = StWaitRelease;
        end else begin
          move_idx_d   = hot_idx;
          move_valid_d = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = StOffer;
        end
      end
      StOffer: begin
        // Acceptance takes priority over a coincident timeout.
        if (move_ready) begin
          move_valid_d = 1'b0;
          state_d      = StWaitRelease;
        end else if (TimeoutEn && tmo_cnt_q == TmoMax) begin
          move_valid_d = 1'b0;
          err_tmo_d    = 1'b1;
          state_d      = StWaitRelease;
        end else if (TimeoutEn) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StWaitRelease: begin
        if (key_deb_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      key_s1_q       <= 1'b1;
      key_s2_q       <= 1'b1;
      key_deb_q      <= 1'b1;
      key_deb_prev_q <= 1'b1;
      sw_s1_q        <= '0;
      sw_s2_q        <= '0;
      sw_q           <= '0;
      deb_cnt_q      <= '0;
      tmo_cnt_q      <= '0;
      state_q        <= StIdle;
      move_valid_q   <= 1'b0;
      move_idx_q     <= '0;
      err_multi_q    <= 1'b0;
      err_occ_q      <= 1'b0;
      err_tmo_q      <= 1'b0;
    end else begin
      key_s1_q       <= key_n;
      key_s2_q       <= key_s1_q;
      key_deb_q      <= key_deb_d;
      key_deb_prev_q <= key_deb_q;
      sw_s1_q        <= sw;
      sw_s2_q        <= sw_s1_q;
      sw_q           <= sw_d;
      deb_cnt_q      <= deb_cnt_d;
      tmo_cnt_q      <= tmo_cnt_d;
      state_q        <= state_d;
      move_valid_q   <= move_valid_d;
      move_idx_q     <= move_idx_d;
      err_multi_q    <= err_multi_d;
      err_occ_q      <= err_occ_d;
      err_tmo_q      <= err_tmo_d;
    end
  end

  assign move_valid   = move_valid_q;
  assign move_idx     = move_idx_q;
  assign err_multi    = err_multi_q;
  assign err_occupied = err_occ_q;
  assign err_timeout  = err_tmo_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed self-checking bench for move_entry (DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 8).
module tb_move_entry;

`ifdef MOVE_TIMEOUT_EN
  localparam int BpCycles = 6;
`else
  localparam int BpCycles = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       key_n;
  logic [8:0] sw;
  logic [8:0] board_occ;
  logic       move_valid;
  logic [3:0] move_idx;
  logic       move_ready;
  logic       err_multi, err_occupied, err_timeout;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_acc = 0, n_multi = 0, n_occ = 0, n_tmo = 0, n_badidx = 0;
  logic [3:0] last_idx = '0;
  int b_valid, b_acc, b_multi, b_occ, b_tmo;
  logic ok;
  int cnt;

  move_entry #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .key_n        (key_n),
    .sw           (sw),
    .board_occ    (board_occ),
    .move_valid   (move_valid),
    .move_idx     (move_idx),
    .move_ready   (move_ready),
    .err_multi    (err_multi),
    .err_occupied (err_occupied),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  // Event counters sampled on the active edge, i.e. the values the DUT sees at handshake time.
  always @(posedge clk) begin
    if (rst) begin
      if (move_valid) n_valid <= n_valid + 1;
      if (move_valid && move_ready) begin
        n_acc    <= n_acc + 1;
        last_idx <= move_idx;
      end
      if (move_valid && move_idx > 4'd8) n_badidx <= n_badidx + 1;
      if (err_multi)    n_multi <= n_multi + 1;
      if (err_occupied) n_occ   <= n_occ + 1;
      if (err_timeout)  n_tmo   <= n_tmo + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_acc   = n_acc;
    b_multi = n_multi;
    b_occ   = n_occ;
    b_tmo   = n_tmo;
  endtask

  task automatic press(input int hold);
    key_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_n = 1'b1;
    repeat (15) @(negedge clk);
  endtask

  task automatic wait_valid(output logic found);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (move_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b0; key_n = 1'b1; sw = '0; board_occ = '0; move_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(move_valid), 0);
    check("reset_idx", 32'(move_idx), 0);
    check("reset_err_multi", 32'(err_multi), 0);
    check("reset_err_occ", 32'(err_occupied), 0);
    check("reset_err_tmo", 32'(err_timeout), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Accept path
    snap(); sw = 9'b000010000; move_ready = 1'b1;
    press(20);
    check("t1_valid_cycles", 32'(n_valid - b_valid), 1);
    check("t1_accepts", 32'(n_acc - b_acc), 1);
    check("t1_idx", 32'(last_idx), 4);
    check("t1_no_err", 32'((n_multi - b_multi) + (n_occ - b_occ)), 0);

    // Multi-select and empty selection
    snap(); sw = 9'b000000011;
    press(20);
    check("t2_multi_pulse", 32'(n_multi - b_multi), 1);
    check("t2_no_valid", 32'(n_valid - b_valid), 0);
    snap(); sw = 9'b000000000;
    press(20);
    check("t2_zero_pulse", 32'(n_multi - b_multi), 1);
    check("t2_zero_no_valid", 32'(n_valid - b_valid), 0);

    // Occupied cell, then free
    snap(); sw = 9'b100000000; board_occ = 9'b100000000;
    press(20);
    check("t3_occ_pulse", 32'(n_occ - b_occ), 1);
    check("t3_occ_no_valid", 32'(n_valid - b_valid), 0);
    check("t3_occ_no_multi", 32'(n_multi - b_multi), 0);
    snap(); board_occ = '0;
    press(20);
    check("t3_free_accept", 32'(n_acc - b_acc), 1);
    check("t3_free_idx", 32'(last_idx), 8);

    // Backpressure with switch change mid-offer
    snap(); sw = 9'b000010000; move_ready = 1'b0; key_n = 1'b0;
    wait_valid(ok);
    check("t4_offer_seen", 32'(ok), 1);
    for (int i = 0; i < BpCycles; i++) begin
      @(negedge clk);
      if (i == 3) sw = 9'b000000001;
      check("t4_hold_valid", 32'(move_valid), 1);
      check("t4_hold_idx", 32'(move_idx), 4);
    end
    move_ready = 1'b1;
    @(negedge clk);
    check("t4_drop_after_accept", 32'(move_valid), 0);
    check("t4_accept_idx", 32'(last_idx), 4);
    key_n = 1'b1;
    repeat (15) @(negedge clk);

    // Bounce, then long hold, then a second press
    snap(); sw = 9'b000000001;
    for (int i = 0; i < 15; i++) begin
      key_n = ~key_n;
      repeat (2) @(negedge clk);
    end
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_bounce_no_offer", 32'(n_valid - b_valid), 0);
    press(100);
    check("t5_hold_one_accept", 32'(n_acc - b_acc), 1);
    check("t5_idx", 32'(last_idx), 0);
    press(20);
    check("t5_repress_accept", 32'(n_acc - b_acc), 2);

    // Reset during offer
    move_ready = 1'b0; sw = 9'b000010000; key_n = 1'b0;
    wait_valid(ok);
    check("t6_offer_seen", 32'(ok), 1);
    key_n = 1'b1; rst = 1'b0;
    #1;
    check("t6_reset_valid", 32'(move_valid), 0);
    check("t6_reset_idx", 32'(move_idx), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    snap(); sw = 9'b000000100; move_ready = 1'b1;
    press(20);
    check("t6_after_reset_accept", 32'(n_acc - b_acc), 1);
    check("t6_after_reset_idx", 32'(last_idx), 2);

    // Offer timeout (or indefinite wait without the option)
    snap(); move_ready = 1'b0; sw = 9'b000001000; key_n = 1'b0;
    wait_valid(ok);
    check("t7_offer_seen", 32'(ok), 1);
`ifdef MOVE_TIMEOUT_EN
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!move_valid) break;
      cnt++;
    end
    check("t7_offer_cycles", 32'(cnt), 8);
    check("t7_tmo_pulse", 32'(n_tmo - b_tmo), 1);
    check("t7_no_accept", 32'(n_acc - b_acc), 0);
    key_n = 1'b1;
    repeat (15) @(negedge clk);
`else
    repeat (40) @(negedge clk);
    check("t7_still_valid", 32'(move_valid), 1);
    check("t7_idx", 32'(move_idx), 3);
    check("t7_no_tmo", 32'(n_tmo - b_tmo), 0);
    move_ready = 1'b1;
    key_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t7_late_accept", 32'(n_acc - b_acc), 1);
`endif
    check("idx_range", 32'(n_badidx), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
